uart_fifo_tx: RTL

//   Transmit-side FIFO between a byte producer (CPU/interface logic) and the UART

---
 rtl/uart_fifo_tx.sv | 113 +++++++++++
 1 files changed

// File: rtl/uart_fifo_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_tx
//  Description : Transmit FIFO feeding a UART transmitter; launches one frame
//                per buffered word and waits for tx_done before the next.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_fifo_tx #(
    parameter int DB = 8,
    parameter int W  = 2
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DB-1:0] w_data,
    input  logic          wr,
    output logic          tx_full,
    output logic          tx_empty,
    output logic [W:0]    count,
    output logic          overflow,
    output logic [DB-1:0] d_in,
    output logic          tx_start,
    input  logic          tx_done
);

    localparam logic [W:0] c_depth = {1'b1, {W{1'b0}}};

    localparam logic [1:0] c_idle  = 2'd0;
    localparam logic [1:0] c_start = 2'd1;
    localparam logic [1:0] c_wait  = 2'd2;

    logic [DB-1:0] r_mem [2**W];
    logic [W-1:0]  r_wr_ptr;
    logic [W-1:0]  r_rd_ptr;
    logic [W:0]    r_count;
    logic          r_overflow;
    logic [DB-1:0] r_d_in;
    logic          r_tx_start;
    logic [1:0]    r_state;

    logic          w_push;
    logic          w_pop;

    // The in-flight word stays counted until tx_done, so full covers it.
    assign tx_full  = (r_count == c_depth);
    assign tx_empty = (r_count == '0);
    assign count    = r_count;
    assign overflow = r_overflow;
    assign d_in     = r_d_in;
    assign tx_start = r_tx_start;

    assign w_push = wr && !tx_full;
    assign w_pop  = (r_state == c_wait) && tx_done;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_d_in     <= '0;
            r_tx_start <= 1'b0;
            r_state    <= c_idle;
        end else begin
            r_overflow <= wr && tx_full;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 1'b1;
            end

            case (r_state)
                c_idle: begin
                    r_tx_start <= 1'b0;
                    if (!tx_empty) begin
                        r_d_in     <= r_mem[r_rd_ptr];
                        r_tx_start <= 1'b1;
                        r_state    <= c_start;
                    end
                end
                c_start: begin
                    r_tx_start <= 1'b0;
                    r_state    <= c_wait;
                end
                c_wait: begin
                    r_tx_start <= 1'b0;
                    if (tx_done) begin
                        r_state <= c_idle;
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_state    <= c_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
